// File: rtl/ppl_dispatch.sv
// Frame-level pixel issue scheduler: walks a frame in raster order and issues
// (x, y, addr) into the render pipeline, limited by in-flight credits.
module ppl_dispatch #(
  parameter int H_DISP  = 1280,
  parameter int V_DISP  = 720,
  parameter int CREDITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        abort,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [10:0] issue_x,
  output logic [9:0]  issue_y,
  output logic [19:0] issue_addr,
  input  logic        retire,
  output logic        busy,
  output logic [5:0]  inflight,
  output logic        frame_done,
  output logic        frame_aborted,
  output logic        underflow_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [10:0] X_LAST = 11'(H_DISP - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_DISP - 1);
  localparam logic [5:0]  CRED   = 6'(CREDITS);

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [19:0] addr_q, addr_d;
  logic [5:0]  inflight_q, inflight_d;
  logic        aborted_q, aborted_d;
  logic        underflow_q, underflow_d;
  logic        xfer, last_pix, retire_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      inflight_q  <= '0;
      aborted_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      inflight_q  <= inflight_d;
      aborted_q   <= aborted_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    issue_valid   = (state_q == ISSUE) && (inflight_q < CRED);
    busy          = (state_q == ISSUE) || (state_q == DRAIN);
    frame_done    = (state_q == DONE);
    issue_x       = x_q;
    issue_y       = y_q;
    issue_addr    = addr_q;
    inflight      = inflight_q;
    frame_aborted = aborted_q;
    underflow_err = underflow_q;
  end

  // A retire with nothing in flight is flagged but never drives the count below zero.
  always_comb begin
    xfer        = issue_valid && issue_ready;
    last_pix    = (x_q == X_LAST) && (y_q == Y_LAST);
    retire_ok   = retire && (inflight_q != 6'd0);
    underflow_d = underflow_q || (retire && (inflight_q == 6'd0));
    inflight_d  = inflight_q + {5'd0, xfer} - {5'd0, retire_ok};
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    aborted_d   = aborted_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          x_d       = '0;
          y_d       = '0;
          addr_d    = '0;
          aborted_d = 1'b0;
        end
      end
      ISSUE: begin
        if (xfer && !last_pix) begin
          addr_d = addr_q + 20'd1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 10'd1;
          end else begin
            x_d = x_q + 11'd1;
          end
        end
        if (abort) aborted_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = ISSUE;
      ISSUE:   if (abort || (xfer && last_pix)) state_d = DRAIN;
      DRAIN:   if (inflight_d == 6'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ppl_dispatch.sv
// Self-checking bench for ppl_dispatch: a pixel-index reference model plus an
// emulated pipeline with random latency, checked against the DUT every cycle.
module tb_ppl_dispatch;

  localparam int H = 4;
  localparam int V = 3;
  localparam int C = 2;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        abort = 1'b0;
  logic        issue_ready = 1'b0;
  logic        retire = 1'b0;
  logic        issue_valid;
  logic [10:0] issue_x;
  logic [9:0]  issue_y;
  logic [19:0] issue_addr;
  logic        busy;
  logic [5:0]  inflight;
  logic        frame_done;
  logic        frame_aborted;
  logic        underflow_err;

  ppl_dispatch #(.H_DISP(H), .V_DISP(V), .CREDITS(C)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_x(issue_x),
    .issue_y(issue_y), .issue_addr(issue_addr), .retire(retire), .busy(busy),
    .inflight(inflight), .frame_done(frame_done), .frame_aborted(frame_aborted),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame progress as a linear pixel index plus an in-flight count.
  bit m_active = 0, m_issuing = 0, m_done = 0, m_aborted = 0, m_underflow = 0;
  int m_pix = 0, m_inflight = 0, m_cyc = 0;
  int pipe[$];

  int  lat_min = 2, lat_max = 2, ready_mode = 0;
  bit  hold_retire = 0, force_retire = 0;
  int  dut_xfers = 0, done_pulses = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int nxt, mi;
    bit xf, rt;
    if (!rst_n) begin
      m_active = 0; m_issuing = 0; m_done = 0; m_aborted = 0; m_underflow = 0;
      m_pix = 0; m_inflight = 0;
      pipe.delete();
    end else begin
      xf = m_issuing && (m_inflight < C) && issue_ready;
      rt = retire && (m_inflight > 0);
      if (retire && m_inflight == 0) m_underflow = 1;
      if (retire && pipe.size() > 0) begin
        mi = 0;
        for (int i = 1; i < pipe.size(); i++) if (pipe[i] < pipe[mi]) mi = i;
        pipe.delete(mi);
      end
      nxt = m_inflight + int'(xf) - int'(rt);
      if (xf) pipe.push_back(m_cyc + $urandom_range(lat_max, lat_min));
      if (m_done) m_done = 0;
      else if (!m_active) begin
        if (frame_start) begin
          m_active = 1; m_issuing = 1; m_pix = 0; m_aborted = 0;
        end
      end else if (m_issuing) begin
        if (xf) begin
          if (m_pix == NPIX - 1) m_issuing = 0;
          else m_pix++;
        end
        if (abort) begin
          m_issuing = 0; m_aborted = 1;
        end
      end else if (nxt == 0) begin
        m_active = 0; m_done = 1;
      end
      m_inflight = nxt;
      m_cyc++;
    end
  end

  // Per-cycle comparison away from the active edge; transfers also pinned to raster order.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("issue_valid", int'(issue_valid), int'(m_issuing && m_inflight < C));
      checkOutput("busy", int'(busy), int'(m_active));
      checkOutput("inflight", int'(inflight), m_inflight);
      checkOutput("frame_done", int'(frame_done), int'(m_done));
      checkOutput("frame_aborted", int'(frame_aborted), int'(m_aborted));
      checkOutput("underflow_err", int'(underflow_err), int'(m_underflow));
      checkOutput("issue_x", int'(issue_x), m_pix % H);
      checkOutput("issue_y", int'(issue_y), m_pix / H);
      checkOutput("issue_addr", int'(issue_addr), m_pix);
      if (frame_start && !busy && !frame_done && rst_n) dut_xfers = 0;
      if (frame_done) done_pulses++;
      if (issue_valid && issue_ready && rst_n) begin
        checkOutput("xfer_addr_order", int'(issue_addr), dut_xfers);
        checkOutput("xfer_x_order", int'(issue_x), dut_xfers % H);
        checkOutput("xfer_y_order", int'(issue_y), dut_xfers / H);
        dut_xfers++;
      end
    end
  end

  task automatic applyStimulus(input logic fs, input logic ab);
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       issue_ready = 1'b1;
      1:       issue_ready = ~issue_ready;
      default: issue_ready = 1'($urandom_range(1, 0));
    endcase
    retire = 1'b0;
    if (force_retire) retire = 1'b1;
    else if (!hold_retire)
      foreach (pipe[i]) if (pipe[i] <= m_cyc) retire = 1'b1;
    frame_start = fs;
    abort = ab;
  endtask

  task automatic startFrame();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic runToEnd(input string name, input int maxc);
    int n = 0;
    while ((m_active || m_done) && n < maxc) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkOutput({name, "_frame_completes"}, int'(n < maxc), 1);
  endtask

  initial begin
    int d0, n;
    $display("[TB] start");
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", int'(issue_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_inflight", int'(inflight), 0);
    checkOutput("rst_addr", int'(issue_addr), 0);
    checkOutput("rst_done", int'(frame_done), 0);
    #1 rst_n = 1'b1;

    // Steady flow: retire two cycles after each transfer.
    d0 = done_pulses;
    startFrame();
    runToEnd("t1", 200);
    checkOutput("t1_xfers", dut_xfers, 12);
    checkOutput("t1_done_pulses", done_pulses - d0, 1);
    checkOutput("t1_inflight", int'(inflight), 0);
    checkOutput("t1_busy", int'(busy), 0);

    // Credit stall with retires withheld.
    hold_retire = 1;
    startFrame();
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("t2_xfers", dut_xfers, 2);
    checkOutput("t2_valid", int'(issue_valid), 0);
    checkOutput("t2_inflight", int'(inflight), 2);
    checkOutput("t2_busy", int'(busy), 1);
    hold_retire = 0;
    runToEnd("t2", 200);
    checkOutput("t2_xfers_total", dut_xfers, 12);

    // Back-pressure with toggling ready.
    ready_mode = 1; lat_min = 1; lat_max = 3;
    startFrame();
    runToEnd("t3", 300);
    checkOutput("t3_xfers", dut_xfers, 12);

    // Abort after the fifth transfer.
    ready_mode = 0; lat_min = 2; lat_max = 2;
    startFrame();
    n = 0;
    while (dut_xfers < 5 && n < 100) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    applyStimulus(1'b0, 1'b1);
    runToEnd("t4", 200);
    checkOutput("t4_aborted", int'(frame_aborted), 1);
    checkOutput("t4_xfers_le6", int'(dut_xfers >= 5 && dut_xfers <= 6), 1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_aborted_cleared", int'(frame_aborted), 0);
    runToEnd("t4b", 200);
    checkOutput("t4b_xfers", dut_xfers, 12);

    // Restart attempts mid-frame, then a stray retire while idle.
    startFrame();
    repeat (3) applyStimulus(1'b1, 1'b0);
    runToEnd("t5", 200);
    checkOutput("t5_xfers", dut_xfers, 12);
    force_retire = 1;
    applyStimulus(1'b0, 1'b0);
    force_retire = 0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_underflow", int'(underflow_err), 1);
    checkOutput("t5_inflight", int'(inflight), 0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("t5_underflow_sticky", int'(underflow_err), 1);

    // Asynchronous reset mid-frame.
    startFrame();
    repeat (4) applyStimulus(1'b0, 1'b0);
    rst_n = 1'b0;
    retire = 1'b0;
    #1;
    checkOutput("t6_valid", int'(issue_valid), 0);
    checkOutput("t6_busy", int'(busy), 0);
    checkOutput("t6_inflight", int'(inflight), 0);
    checkOutput("t6_addr", int'(issue_addr), 0);
    checkOutput("t6_underflow", int'(underflow_err), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    startFrame();
    runToEnd("t6", 200);
    checkOutput("t6_xfers", dut_xfers, 12);

    // Randomized traffic with occasional aborts.
    ready_mode = 2; lat_min = 1; lat_max = 4;
    for (int f = 0; f < 8; f++) begin
      startFrame();
      n = 0;
      while ((m_active || m_done) && n < 400) begin
        applyStimulus(1'b0, 1'($urandom_range(29, 0) == 0));
        n++;
      end
      checkOutput("rand_frame_completes", int'(n < 400), 1);
    end

    repeat (3) applyStimulus(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
